// File: rtl/spi_bus_arbiter_if.sv
// Bus bundle between the SPI arbiter, its three requesters and the SPI master.
// The master modport is the arbiter side; the slave modport is the environment side.
interface spi_bus_arbiter_if;
  logic [2:0]  req;
  logic [47:0] req_cmd;
  logic [8:0]  req_ss;
  logic [2:0]  gnt;
  logic [2:0]  done;
  logic        err;
  logic [15:0] rd_data;
  logic        wrt_SPI;
  logic [15:0] SPI_cmd;
  logic        SPI_done;
  logic [15:0] SPI_data;
  logic [2:0]  ss;

  modport master (
    input  req, req_cmd, req_ss,
    input  SPI_done, SPI_data,
    output gnt, done, err, rd_data,
    output wrt_SPI, SPI_cmd, ss
  );

  modport slave (
    output req, req_cmd, req_ss,
    output SPI_done, SPI_data,
    input  gnt, done, err, rd_data,
    input  wrt_SPI, SPI_cmd, ss
  );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI master among three requesters,
// with a per-transaction watchdog and an idle gap between transactions.
module spi_bus_arbiter #(
  parameter int TIMEOUT = 4096,
  parameter int GAP_CYC = 4
) (
  input logic               clk,
  input logic               rst_n,
  spi_bus_arbiter_if.master bus
);
  localparam int WDW = $clog2(TIMEOUT) + 1;
  localparam int GW  = $clog2(GAP_CYC) + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_BUSY   = 2'd2;
  localparam logic [1:0] S_GAP    = 2'd3;

  localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);
  localparam logic [GW-1:0]  GAP_LAST = GW'(GAP_CYC - 1);

  logic [1:0]     r_state;
  logic [1:0]     r_rr;
  logic [1:0]     r_win;
  logic [WDW-1:0] r_wdog;
  logic [GW-1:0]  r_gap;
  logic [2:0]     r_gnt;
  logic [2:0]     r_done;
  logic           r_err;
  logic [15:0]    r_rd;
  logic           r_wrt;
  logic [15:0]    r_cmd;
  logic [2:0]     r_ss;

  logic [1:0]  w_win;
  logic        w_any;
  logic [15:0] w_cmd;
  logic [2:0]  w_ss;
  logic [1:0]  w_rr_nxt;

  // first asserted request scanning upward from the rr pointer
  always_comb begin
    w_any = |bus.req;
    w_win = r_rr;
    case (r_rr)
      2'd1: w_win = bus.req[1] ? 2'd1 :
                    bus.req[2] ? 2'd2 :
                    bus.req[0] ? 2'd0 : 2'd1;
      2'd2: w_win = bus.req[2] ? 2'd2 :
                    bus.req[0] ? 2'd0 :
                    bus.req[1] ? 2'd1 : 2'd2;
      default: w_win = bus.req[0] ? 2'd0 :
                       bus.req[1] ? 2'd1 :
                       bus.req[2] ? 2'd2 : 2'd0;
    endcase
  end

  always_comb begin
    w_cmd = bus.req_cmd[15:0];
    w_ss  = bus.req_ss[2:0];
    case (w_win)
      2'd1: begin
        w_cmd = bus.req_cmd[31:16];
        w_ss  = bus.req_ss[5:3];
      end
      2'd2: begin
        w_cmd = bus.req_cmd[47:32];
        w_ss  = bus.req_ss[8:6];
      end
      default: begin
        w_cmd = bus.req_cmd[15:0];
        w_ss  = bus.req_ss[2:0];
      end
    endcase
  end

  assign w_rr_nxt = (r_win == 2'd2) ? 2'd0 : r_win + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rr    <= '0;
      r_win   <= '0;
      r_wdog  <= '0;
      r_gap   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_err   <= 1'b0;
      r_rd    <= '0;
      r_wrt   <= 1'b0;
      r_cmd   <= '0;
      r_ss    <= 3'b111;
    end else begin
      r_done <= '0;
      r_err  <= 1'b0;
      r_wrt  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_win   <= w_win;
            r_gnt   <= 3'b001 << w_win;
            r_cmd   <= w_cmd;
            r_ss    <= w_ss;
            r_state <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_wrt   <= 1'b1;
          r_wdog  <= '0;
          r_state <= S_BUSY;
        end
        S_BUSY: begin
          if (bus.SPI_done) begin
            r_rd    <= bus.SPI_data;
            r_done  <= r_gnt;
            r_gnt   <= '0;
            r_rr    <= w_rr_nxt;
            r_ss    <= 3'b111;
            r_gap   <= '0;
            r_state <= S_GAP;
          end else if (r_wdog == WD_LAST) begin
            // abort: requester still gets its done, flagged by err
            r_done  <= r_gnt;
            r_err   <= 1'b1;
            r_gnt   <= '0;
            r_rr    <= w_rr_nxt;
            r_ss    <= 3'b111;
            r_gap   <= '0;
            r_state <= S_GAP;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        S_GAP: begin
          if (r_gap == GAP_LAST) r_state <= S_IDLE;
          else r_gap <= r_gap + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.done    = r_done;
  assign bus.err     = r_err;
  assign bus.rd_data = r_rd;
  assign bus.wrt_SPI = r_wrt;
  assign bus.SPI_cmd = r_cmd;
  assign bus.ss      = r_ss;
endmodule
